// File: rtl/enc_key_pkg.sv
// enc_key_pkg: state encoding and default key shared by the key encoder, decoder side and benches
package enc_key_pkg;
   typedef enum logic [2:0] {IDLE, SEND_KEY, SEND_ARM, UNLOCKED, RELOCK} state_t;
   localparam int KEY_WIDTH_DEF = 4;
   localparam logic [KEY_WIDTH_DEF-1:0] KEY_DEFAULT = 4'b1010;
endpackage

// File: rtl/enc_input_key_key_shifter.sv
// key_shifter: loadable MSB-first shift register with a down-counter flagging the last bit
module key_shifter #(
   parameter int W = 4
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         i_load,
   input  logic         i_shift,
   input  logic [W-1:0] i_key,
   output logic         o_msb,
   output logic         o_last
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   logic [W-1:0]  r_shift;
   logic [CW-1:0] r_cnt;
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_load) begin
         r_shift <= i_key;
         r_cnt   <= CW'(W - 1);
      end else if (i_shift) begin
         r_shift <= r_shift << 1;
         r_cnt   <= r_cnt - CW'(1);
      end
   assign o_msb  = r_shift[W-1];
   assign o_last = r_cnt == '0;
endmodule

// File: rtl/enc_input_key.sv
// enc_input_key: sends an unlock key plus arm strobe to the mode decoder, then drives the mode level
// Outputs are registered from the current state, so they trail the state register by one cycle.
module enc_input_key
   import enc_key_pkg::*;
#(
   parameter int                   KEY_WIDTH   = KEY_WIDTH_DEF,
   parameter logic [KEY_WIDTH-1:0] KEY_DEFAULT = enc_key_pkg::KEY_DEFAULT
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic                 KeySel,
   input  logic [KEY_WIDTH-1:0] KeyIn,
   input  logic                 ModeWr,
   input  logic                 ModeIn,
   input  logic                 Relock,
   output logic                 InputKey,
   output logic                 ValidCmd,
   output logic                 PeerRst,
   output logic                 Busy,
   output logic                 Unlocked,
   output logic                 StartErr
);
   state_t r_state, w_next;
   logic r_mode, r_key, r_valid, r_peer, r_busy, r_unl, r_err;
   logic w_load, w_shift, w_msb, w_last;
   logic w_key, w_valid, w_peer, w_busy, w_unl, w_err;

   key_shifter #(.W(KEY_WIDTH)) u_shifter (
      .Clk    (Clk),
      .Reset  (Reset),
      .i_load (w_load),
      .i_shift(w_shift),
      .i_key  (KeySel ? KeyIn : KEY_DEFAULT),
      .o_msb  (w_msb),
      .o_last (w_last)
   );

   always_ff @(posedge Clk or posedge Reset)
      if (Reset) r_state <= IDLE;
      else       r_state <= w_next;

   always_comb begin
      w_next  = r_state;
      w_load  = 1'b0;
      w_shift = 1'b0;
      w_key   = 1'b0;
      w_valid = 1'b0;
      w_peer  = 1'b0;
      w_busy  = 1'b0;
      w_unl   = 1'b0;
      w_err   = r_err | (Start & (r_state != IDLE));
      case (r_state)
         IDLE: begin
            w_load = Start;
            w_next = Start ? SEND_KEY : IDLE;
         end
         SEND_KEY: begin
            w_valid = 1'b1;
            w_busy  = 1'b1;
            w_key   = w_msb;
            w_shift = 1'b1;
            w_next  = w_last ? SEND_ARM : SEND_KEY;
         end
         SEND_ARM: begin
            w_valid = 1'b1;
            w_busy  = 1'b1;
            w_next  = UNLOCKED;
         end
         UNLOCKED: begin
            // a write shows its new level together with its strobe; relock suppresses the strobe
            w_unl   = 1'b1;
            w_key   = ModeWr ? ModeIn : r_mode;
            w_valid = ModeWr & ~Relock;
            w_next  = Relock ? RELOCK : UNLOCKED;
         end
         RELOCK: begin
            w_peer = 1'b1;
            w_busy = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         r_mode  <= 1'b0;
         r_key   <= 1'b0;
         r_valid <= 1'b0;
         r_peer  <= 1'b0;
         r_busy  <= 1'b0;
         r_unl   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_mode  <= ModeWr ? ModeIn : r_mode;
         r_key   <= w_key;
         r_valid <= w_valid;
         r_peer  <= w_peer;
         r_busy  <= w_busy;
         r_unl   <= w_unl;
         r_err   <= w_err;
      end

   assign InputKey = r_key;
   assign ValidCmd = r_valid;
   assign PeerRst  = r_peer;
   assign Busy     = r_busy;
   assign Unlocked = r_unl;
   assign StartErr = r_err;
endmodule

// File: tb/tb_enc_input_key.sv
// tb_enc_input_key: directed vectors for the key encoder; outputs packed as {InputKey,ValidCmd,PeerRst,Busy,Unlocked,StartErr}
module tb_enc_input_key;
   logic       Clk = 1'b0, Reset = 1'b1;
   logic       Start = 1'b0, KeySel = 1'b0, ModeWr = 1'b0, ModeIn = 1'b0, Relock = 1'b0;
   logic [3:0] KeyIn = 4'b0000;
   logic       InputKey, ValidCmd, PeerRst, Busy, Unlocked, StartErr;
   int         n_vec = 0, n_err = 0;

   enc_input_key dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .KeySel(KeySel), .KeyIn(KeyIn),
      .ModeWr(ModeWr), .ModeIn(ModeIn), .Relock(Relock),
      .InputKey(InputKey), .ValidCmd(ValidCmd), .PeerRst(PeerRst),
      .Busy(Busy), .Unlocked(Unlocked), .StartErr(StartErr)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [5:0] exp);
      logic [5:0] obs;
      obs = {InputKey, ValidCmd, PeerRst, Busy, Unlocked, StartErr};
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // key bits with ValidCmd/Busy high, then the arm cycle, then the first UNLOCKED cycle
   task automatic send_key(input string tag, input logic [3:0] key, input logic err, input logic mode);
      logic [3:0] k;
      k = key;
      for (int i = 3; i >= 0; i--) begin
         tick();
         chk($sformatf("%s_bit%0d", tag, i), {k[i], 1'b1, 1'b0, 1'b1, 1'b0, err});
      end
      tick();
      chk({tag, "_arm"}, {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, err});
      tick();
      chk({tag, "_unlocked"}, {mode, 1'b0, 1'b0, 1'b0, 1'b1, err});
   endtask

   initial begin
      tick();
      tick();
      chk("reset_state", 6'b000000);
      Reset = 1'b0;
      tick();
      chk("idle_after_reset", 6'b000000);

      Start = 1'b1;
      tick();
      Start = 1'b0;
      chk("start_edge", 6'b000000);
      send_key("default", 4'b1010, 1'b0, 1'b0);

      ModeWr = 1'b1; ModeIn = 1'b1;
      tick();
      chk("mode_wr1", 6'b110010);
      ModeIn = 1'b0;
      tick();
      chk("mode_wr0", 6'b010010);
      ModeWr = 1'b0;
      tick();
      chk("mode_hold", 6'b000010);

      Relock = 1'b1; ModeWr = 1'b1; ModeIn = 1'b1;
      tick();
      Relock = 1'b0; ModeWr = 1'b0; ModeIn = 1'b0;
      chk("relock_edge", 6'b100010);
      tick();
      chk("relock_peerrst", 6'b001100);
      tick();
      chk("relock_idle", 6'b000000);

      Relock = 1'b1;
      tick();
      Relock = 1'b0;
      chk("relock_in_idle", 6'b000000);
      tick();
      chk("relock_in_idle2", 6'b000000);

      Start = 1'b1;
      tick();
      Start = 1'b0;
      chk("restart_edge", 6'b000000);
      send_key("mode_kept", 4'b1010, 1'b0, 1'b1);
      Relock = 1'b1;
      tick();
      Relock = 1'b0;
      chk("relock2_edge", 6'b100010);
      tick();
      chk("relock2_peerrst", 6'b001100);
      tick();
      chk("relock2_idle", 6'b000000);

      Start = 1'b1; KeySel = 1'b1; KeyIn = 4'b0110;
      tick();
      Start = 1'b0; KeySel = 1'b0; KeyIn = 4'b0000;
      chk("runtime_start", 6'b000000);
      tick();
      chk("runtime_bit3", 6'b010100);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      chk("runtime_bit2_err", 6'b110101);
      tick();
      chk("runtime_bit1", 6'b110101);
      tick();
      chk("runtime_bit0", 6'b010101);
      tick();
      chk("runtime_arm", 6'b010101);
      tick();
      chk("runtime_unlocked", 6'b100011);
      Relock = 1'b1;
      tick();
      Relock = 1'b0;
      tick();
      chk("runtime_peerrst", 6'b001101);
      tick();
      chk("err_sticky_idle", 6'b000001);

      Start = 1'b1;
      tick();
      Start = 1'b0;
      tick();
      chk("mid_bit3", 6'b110101);
      tick();
      chk("mid_bit2", 6'b010101);
      tick();
      chk("mid_bit1", 6'b110101);
      Reset = 1'b1;
      #2;
      chk("async_reset", 6'b000000);
      tick();
      Reset = 1'b0;
      chk("reset_held", 6'b000000);

      Start = 1'b1;
      tick();
      Start = 1'b0;
      chk("post_reset_start", 6'b000000);
      send_key("post_reset", 4'b1010, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/enc_input_key.md
Name: enc_input_key

Overview:
Transmit-side partner of the key-gated mode decoder. On a start request it serialises a KEY_WIDTH-bit unlock key, MSB first, onto InputKey with a contiguous ValidCmd strobe, then sends one arm strobe. After that it holds the unlocked link and drives the requested mode level on InputKey. It sits between the control/host logic and the decoder's InputKey/ValidCmd pins.

Parameters:
KEY_WIDTH, 4, number of key bits sent per unlock sequence
KEY_DEFAULT, 4'b1010, key used when KeySel=0; sent MSB first as 1,0,1,0

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  single-cycle request to begin the unlock sequence; honoured only in IDLE
KeySel  in  1  sampled with Start: 0 sends KEY_DEFAULT, 1 sends KeyIn
KeyIn  in  KEY_WIDTH  runtime key, sampled on an accepted Start
ModeWr  in  1  write strobe for the mode register
ModeIn  in  1  new mode value, captured when ModeWr=1
Relock  in  1  request to drop the unlocked link; honoured only in UNLOCKED
InputKey  out  1  serial key bit / mode level to the decoder (registered)
ValidCmd  out  1  command strobe to the decoder (registered)
PeerRst  out  1  one-cycle pulse used to reset the decoder on relock (registered)
Busy  out  1  high in SEND_KEY, SEND_ARM and RELOCK
Unlocked  out  1  high in UNLOCKED
StartErr  out  1  sticky; set when Start arrives outside IDLE; cleared only by Reset

Behaviour:
- Reset (asynchronous, any state): state=IDLE. InputKey, ValidCmd, PeerRst, Busy, Unlocked, StartErr, bit counter, shift register and mode register all go to 0.
- All outputs are registered. A Start sampled at edge N produces the first key bit on the outputs after edge N+1.
- IDLE: ValidCmd=0, InputKey=0.
  - Start=1: load the shift register with the selected key, set bit counter=KEY_WIDTH-1, go to SEND_KEY.
- SEND_KEY: ValidCmd=1, InputKey=shift[MSB].
  - Shift left each cycle; counter decrements.
  - When the counter reaches 0, go to SEND_ARM.
  - ValidCmd must never drop inside SEND_KEY/SEND_ARM; a gap makes the decoder lock out permanently.
- SEND_ARM: exactly one cycle, ValidCmd=1, InputKey=0. Then go to UNLOCKED.
- UNLOCKED: Unlocked=1, InputKey=mode register, ValidCmd=0 except for the pulse below.
  - ModeWr=1: the mode register takes ModeIn. On the next cycle InputKey shows the new value and ValidCmd pulses high for exactly 1 cycle.
  - Back-to-back ModeWr: one pulse per write, with ValidCmd high on consecutive cycles.
  - Relock=1: go to RELOCK.
  - Relock and ModeWr in the same cycle: Relock wins, but the mode register still updates.
- RELOCK: PeerRst=1 for 1 cycle, ValidCmd=0, InputKey=0. Then go to IDLE.
- Mode register: ModeWr is accepted in every state. Its value reaches InputKey only in UNLOCKED, and the mode register is preserved across relock.
- Start outside IDLE is ignored and sets StartErr. Relock outside UNLOCKED is ignored with no flag.
- Start and Reset together: Reset dominates.
- Reset mid-sequence: outputs drop to 0 immediately. The decoder shares the system Reset, so both ends return to IDLE together.
- Total unlock latency: Unlocked rises KEY_WIDTH+2 edges after the Start edge (6 for default).
- Illegal state encodings recover to IDLE with outputs 0.

Decomposition:
- Package enc_key_pkg holds:
  - state enum IDLE, SEND_KEY, SEND_ARM, UNLOCKED, RELOCK
  - KEY_WIDTH_DEF=4 and KEY_DEFAULT=4'b1010, shared with the decoder side and benches
- One sub-module is natural: key_shifter (loadable MSB-first shift register plus down-counter, asserting a last-bit flag).
- The FSM and output registers stay in the top level.

Test Plan:
- Reset, then Start with KeySel=0 → over 4 cycles ValidCmd=1 and InputKey=1,0,1,0; then 1 cycle ValidCmd=1/InputKey=0; Unlocked=1 at edge 6; a paired decoder shows Active=1.
- KeySel=1, KeyIn=4'b0110 → InputKey=0,1,1,0 with ValidCmd continuous; paired decoder stays inactive (wrong key).
- In UNLOCKED, ModeWr with ModeIn=1, then 0 on the next cycle → InputKey 1 then 0; two consecutive one-cycle ValidCmd pulses; decoder Mode follows.
- Start while in SEND_KEY → sequence undisturbed, StartErr=1 and sticky; Relock in IDLE → no effect.
- Relock in UNLOCKED with simultaneous ModeWr=1 → PeerRst pulses 1 cycle, then IDLE; next unlock shows InputKey=1 in UNLOCKED.
- Reset asserted during the 3rd key bit → all outputs 0 asynchronously; after release, Start re-sends the full key from the MSB.
